// File: rtl/load_store_unit.sv
// load_store_unit: serialises word/half/byte accesses into little-endian byte beats on a byte-wide memory.
// Define LSU_MISALIGN_EN to allow misaligned addresses; otherwise they return a one-cycle error.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZW   = $clog2(BYTES);
    localparam int CW    = (SZW > 0) ? SZW : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, last_q, last_d;
    logic                  write_q, write_d, signed_q, signed_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, acc_q, acc_d;
    logic                  mem_en_q, mem_en_d, mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  aligned, legal;

`ifdef LSU_MISALIGN_EN
    assign aligned = 1'b1;
`else
    logic [ADDR_WIDTH-1:0] mask;
    assign mask    = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);
    assign aligned = (req_addr & mask) == '0;
`endif
    assign legal = (int'(req_size) <= SZW) && aligned;

    assign req_ready  = (state_q == S_IDLE) || (state_q == S_RESP);
    assign busy       = (state_q == S_ACCESS) || (state_q == S_WAIT);
    assign mem_en     = mem_en_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            acc_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            mem_en_q     <= mem_en_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        write_d      = write_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        mem_en_d     = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_ACCESS: begin
                // read data lags its beat by one cycle, so beat k-1's byte lands while beat k is on the bus
                if (!write_q && cnt_q != '0) acc_d[8*(int'(cnt_q)-1) +: 8] = mem_rdata;
                if (cnt_q == last_q) begin
                    state_d = write_q ? S_RESP : S_WAIT;
                    if (write_q) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = '0;
                    end
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    mem_en_d    = 1'b1;
                    mem_write_d = write_q;
                    mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    mem_wdata_d = write_q ? wdata_q[7:0] : 8'h00;
                    wdata_d     = wdata_q >> 8;
                end
            end
            S_WAIT: begin
                acc_d[8*int'(last_q) +: 8] = mem_rdata;
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                for (int i = 0; i < DATA_WIDTH; i++)
                    resp_rdata_d[i] = (i < 8*(int'(last_q)+1)) ? acc_d[i] : (signed_q & acc_d[8*int'(last_q)+7]);
            end
            default: begin
                if (req_valid) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    last_d   = CW'((32'd1 << req_size) - 32'd1);
                    acc_d    = '0;
                    if (legal) begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        mem_en_d    = 1'b1;
                        mem_write_d = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_write ? req_wdata[7:0] : 8'h00;
                        wdata_d     = req_wdata >> 8;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a byte-wide synchronous memory.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, busy, mem_en, mem_write;
    logic [31:0] resp_rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_a = '0;
    logic [7:0]  pl_d = '0;

    int          tests = 0, fails = 0, lat, nb;
    logic [31:0] b_addr [0:7];
    logic [7:0]  b_data [0:7];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy), .mem_en(mem_en),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_en && mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_en && !mem_write) mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        nb = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (nb < 8) begin
                    b_addr[nb] = mem_addr;
                    b_data[nb] = mem_wdata;
                end
                nb++;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({req_ready, busy, resp_valid, resp_err} !== 4'b1000) begin fails++; $display("FAIL reset_ctrl got %b exp 1000", {req_ready, busy, resp_valid, resp_err}); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        tests++; if ({mem_en, mem_write} !== 2'b00) begin fails++; $display("FAIL reset_mem_ctl got %b exp 00", {mem_en, mem_write}); end
        tests++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin fails++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
        #1 reset = 1'b0;
    endtask

    task automatic test_store_word;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hA1B2C3D4);
        tests++; if (lat !== 5) begin fails++; $display("FAIL store_word_lat got %0d exp 5", lat); end
        tests++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL store_word_resp got %b/%h exp 0/0", resp_err, resp_rdata); end
        tests++; if (nb !== 4) begin fails++; $display("FAIL store_word_beats got %0d exp 4", nb); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (b_addr[k] !== 32'h100 + k || b_data[k] !== exp_b[k]) begin fails++; $display("FAIL store_word_beat%0d got %h/%h exp %h/%h", k, b_addr[k], b_data[k], 32'h100 + k, exp_b[k]); end
        end
        tests++; if (mem[10'h103] !== 8'hA1) begin fails++; $display("FAIL store_word_mem got %h exp a1", mem[10'h103]); end
    endtask

    task automatic test_load;
        preload(10'h101, 8'h80);
        preload(10'h110, 8'h01);
        preload(10'h111, 8'h80);
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        tests++; if (lat !== 3) begin fails++; $display("FAIL load_byte_lat got %0d exp 3", lat); end
        tests++; if (resp_rdata !== 32'hFFFFFF80 || resp_err !== 1'b0) begin fails++; $display("FAIL load_byte_signed got %h/%b exp ffffff80/0", resp_rdata, resp_err); end
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        tests++; if (resp_rdata !== 32'h00000080) begin fails++; $display("FAIL load_byte_unsigned got %h exp 00000080", resp_rdata); end
        do_req(1'b0, 2'd1, 1'b1, 32'h110, 32'h0);
        tests++; if (lat !== 4 || resp_rdata !== 32'hFFFF8001) begin fails++; $display("FAIL load_half_signed got %0d/%h exp 4/ffff8001", lat, resp_rdata); end
        do_req(1'b0, 2'd1, 1'b0, 32'h110, 32'h0);
        tests++; if (resp_rdata !== 32'h00008001) begin fails++; $display("FAIL load_half_unsigned got %h exp 00008001", resp_rdata); end
        do_req(1'b0, 2'd2, 1'b1, 32'h100, 32'h0);
        tests++; if (lat !== 6 || resp_rdata !== 32'hA1B280D4) begin fails++; $display("FAIL load_word got %0d/%h exp 6/a1b280d4", lat, resp_rdata); end
    endtask

    task automatic test_misalign;
        preload(10'h104, 8'h11);
        preload(10'h105, 8'h22);
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_EN
        tests++; if (lat !== 6 || resp_err !== 1'b0) begin fails++; $display("FAIL misalign_lat got %0d/%b exp 6/0", lat, resp_err); end
        tests++; if (resp_rdata !== 32'h2211A1B2) begin fails++; $display("FAIL misalign_data got %h exp 2211a1b2", resp_rdata); end
        tests++; if (nb !== 4 || b_addr[0] !== 32'h102) begin fails++; $display("FAIL misalign_beats got %0d/%h exp 4/102", nb, b_addr[0]); end
`else
        tests++; if (lat !== 1 || resp_err !== 1'b1) begin fails++; $display("FAIL misalign_err got %0d/%b exp 1/1", lat, resp_err); end
        tests++; if (resp_rdata !== 32'h0 || nb !== 0) begin fails++; $display("FAIL misalign_nobeat got %h/%0d exp 0/0", resp_rdata, nb); end
`endif
    endtask

    task automatic test_size3;
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        tests++; if (lat !== 1 || resp_err !== 1'b1) begin fails++; $display("FAIL size3_err got %0d/%b exp 1/1", lat, resp_err); end
        tests++; if (resp_rdata !== 32'h0 || nb !== 0) begin fails++; $display("FAIL size3_nobeat got %h/%0d exp 0/0", resp_rdata, nb); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h120; req_wdata = 32'h00005A6B;
        @(posedge clk); #1;
        req_write = 1'b0; req_size = 2'd0; req_addr = 32'h121; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        tests++; if ({resp_valid, resp_err, req_ready} !== 3'b101) begin fails++; $display("FAIL b2b_store_resp got %b exp 101", {resp_valid, resp_err, req_ready}); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        tests++; if ({mem_en, mem_write} !== 2'b10 || mem_addr !== 32'h121) begin fails++; $display("FAIL b2b_load_beat got %b/%h exp 10/121", {mem_en, mem_write}, mem_addr); end
        repeat (2) @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000005A) begin fails++; $display("FAIL b2b_load_resp got %b/%h exp 1/0000005a", resp_valid, resp_rdata); end
    endtask

    task automatic test_reset_mid;
        int seen;
        preload(10'h143, 8'h00);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h140; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++; if ({mem_en, mem_write, req_ready, busy} !== 4'b0010) begin fails++; $display("FAIL rst_mid_state got %b exp 0010", {mem_en, mem_write, req_ready, busy}); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || mem_en) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_quiet got %0d exp 0", seen); end
        tests++; if (mem[10'h140] !== 8'h88 || mem[10'h141] !== 8'h77 || mem[10'h143] !== 8'h00) begin fails++; $display("FAIL rst_mid_mem got %h%h%h exp 887700", mem[10'h140], mem[10'h141], mem[10'h143]); end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h101;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_en || busy) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_drop got %0d exp 0", seen); end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_load;
        test_misalign;
        test_size3;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
